mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage CPU, directly upstream of the write-back stage.
- Takes EX/MEM control and data, runs a req/ack transaction with the data memory for loads and stores, and handles byte lanes and load extension.
- Drives the registered MEM/WB outputs that write-back consumes: RegWrite, MemtoReg, memdata, ALUResult and regdst.
- Raises a stall to the upstream stages while an access is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, register/data width; fixed at 32 (byte-lane logic assumes 4 lanes).

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM holds a valid instruction.
- MemRead  in  1  load.
- MemWrite  in  1  store.
- RegWrite  in  1  instruction writes the register file.
- MemtoReg  in  1  write-back selects memory data.
- mem_size  in  2  00 byte, 01 half, 10/11 word.
- mem_unsigned  in  1  zero-extend loads when 1.
- ALUResult  in  32  ALU result / effective address.
- store_data  in  32  rt value for stores.
- regdst  in  5  destination register.
- mem_stall  out  1  hold upstream pipeline.
- data_req  out  1  memory request.
- data_wr  out  1  1 store, 0 load.
- data_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- data_be  out  4  byte enables.
- data_wdata  out  32  lane-replicated store data.
- data_rdata  in  32  read word.
- data_ack  in  1  access complete, rdata valid this cycle.
- mem_RegWrite, mem_MemtoReg  out  1 each  to write-back.
- mem_memdata  out  32  extended load result.
- mem_ALUResult  out  32  to write-back.
- mem_regdst  out  5  to write-back.
- mem_addr_err  out  1  misaligned access flag (see Optional Feature).

Behaviour:
- Reset: asynchronous on resetn low. State=IDLE; every registered output 0; data_req=0; mem_stall=0.
- FSM has two states, IDLE and ACCESS.
- IDLE, non-memory op (in_valid & !MemRead & !MemWrite): MEM/WB outputs load from the inputs at the next edge. Latency is 1. No stall.
- IDLE, memory op: mem_stall=1 combinationally. At the edge:
  - latch address, size, unsigned, store data, regdst and controls;
  - go to ACCESS;
  - mem_RegWrite <= 0 (bubble).
- IDLE, in_valid=0: bubble with all MEM/WB outputs 0.
- ACCESS:
  - data_req=1; data_addr, data_be, data_wdata and data_wr are driven from the latched values and held stable until ack.
  - mem_stall = !data_ack.
  - Each non-ack cycle inserts a bubble (mem_RegWrite=0).
- On data_ack: register the extracted load data into mem_memdata, pass the latched controls, return to IDLE. Upstream advances in that same cycle.
- Minimum memory-op latency is 2 cycles: ack in the first ACCESS cycle is legal.
- data_ack in IDLE is ignored.
- Byte enables:
  - byte: 4'b0001 << addr[1:0];
  - half: addr[1] ? 1100 : 0011;
  - word: 1111.
- Store data lanes: byte = {4{sd[7:0]}}, half = {2{sd[15:0]}}, word = sd.
- Load extraction: byte = rdata >> 8*addr[1:0]; half = rdata >> 16*addr[1]. Then sign-extend, or zero-extend if mem_unsigned. Word loads are unchanged.
- mem_ALUResult for loads/stores carries the address.
- Reset during ACCESS aborts the transaction immediately: data_req drops and no write-back is produced.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Enabled, misaligned access (half with addr[0]=1, word with addr[1:0]!=0):
  - no request issued, no stall;
  - 1-cycle pass with mem_RegWrite forced 0;
  - mem_addr_err=1 for that one registered cycle.
- Disabled:
  - mem_addr_err is tied 0;
  - misaligned word uses the aligned word;
  - misaligned half ignores addr[0].

Test Plan:
- ADDU result 0x00000005 to $3, no mem op -> next cycle mem_RegWrite=1, mem_ALUResult=5, mem_regdst=3, mem_stall never 1.
- LW addr 0x100, ack after 3 ACCESS cycles, rdata 0xDEADBEEF -> data_req high 3 cycles, data_be=1111, mem_stall high 3 cycles. mem_memdata=0xDEADBEEF with mem_RegWrite=1 exactly once.
- LB addr 0x203, rdata 0x80AABBCC, signed -> 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x302, store_data 0x1234ABCD -> data_be=1100, data_wdata=0xABCDABCD, data_wr=1, mem_RegWrite=0.
- resetn pulsed low mid-ACCESS -> data_req and all outputs 0 asynchronously. After release, a fresh LW completes normally.
- With MEM_ALIGN_CHECK_EN: LW addr 0x102 -> no data_req, mem_addr_err=1 for 1 cycle, mem_RegWrite=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data-memory transactions, byte lanes, load extension, MEM/WB registers.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        regdst,
    output logic              mem_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_be,
    output logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_ack,
    output logic              mem_RegWrite,
    output logic              mem_MemtoReg,
    output logic [DATA_W-1:0] mem_memdata,
    output logic [DATA_W-1:0] mem_ALUResult,
    output logic [4:0]        mem_regdst,
    output logic              mem_addr_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] alu_q, alu_d, sd_q, sd_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d, wr_q, wr_d, rw_q, rw_d, m2r_q, m2r_d;
    logic [4:0]        dst_q, dst_d;

    logic              wb_rw_q, wb_rw_d, wb_m2r_q, wb_m2r_d, err_q, err_d;
    logic [DATA_W-1:0] wb_md_q, wb_md_d, wb_alu_q, wb_alu_d;
    logic [4:0]        wb_dst_q, wb_dst_d;

    logic              is_mem, align_err, go_mem;
    logic [DATA_W-1:0] byte_sh, half_sh, load_ext;

    assign is_mem = in_valid & (MemRead | MemWrite);

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        align_err = 1'b0;
        if (is_mem) begin
            if (mem_size == 2'b01)
                align_err = ALUResult[0];
            else if (mem_size[1])
                align_err = (ALUResult[1:0] != 2'b00);
        end
    end
`else
    assign align_err = 1'b0;
`endif

    assign go_mem = is_mem & ~align_err;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_mem)   state_d = ACCESS;
            ACCESS:  if (data_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; stall is gated by resetn so it reads 0 while reset is held
    always_comb begin
        data_req  = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            IDLE:    mem_stall = resetn & go_mem;
            ACCESS: begin
                data_req  = 1'b1;
                mem_stall = ~data_ack;
            end
            default: ;
        endcase
    end

    assign data_wr    = wr_q;
    assign data_addr  = {alu_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        case (size_q)
            2'b00:   data_be = 4'b0001 << alu_q[1:0];
            2'b01:   data_be = alu_q[1] ? 4'b1100 : 4'b0011;
            default: data_be = 4'b1111;
        endcase
        case (size_q)
            2'b00:   data_wdata = {4{sd_q[7:0]}};
            2'b01:   data_wdata = {2{sd_q[15:0]}};
            default: data_wdata = sd_q;
        endcase
    end

    always_comb begin
        byte_sh = data_rdata >> {alu_q[1:0], 3'b000};
        half_sh = data_rdata >> {alu_q[1], 4'b0000};
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, byte_sh[7:0]}
                                      : {{24{byte_sh[7]}}, byte_sh[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0, half_sh[15:0]}
                                      : {{16{half_sh[15]}}, half_sh[15:0]};
            default: load_ext = data_rdata;
        endcase
    end

    // Latched transaction holds its value; MEM/WB defaults to a bubble every cycle
    always_comb begin
        alu_d    = alu_q;
        sd_d     = sd_q;
        size_d   = size_q;
        uns_d    = uns_q;
        wr_d     = wr_q;
        rw_d     = rw_q;
        m2r_d    = m2r_q;
        dst_d    = dst_q;
        wb_rw_d  = 1'b0;
        wb_m2r_d = 1'b0;
        wb_md_d  = '0;
        wb_alu_d = '0;
        wb_dst_d = '0;
        err_d    = 1'b0;
        if (state_q == IDLE) begin
            if (go_mem) begin
                alu_d  = ALUResult;
                sd_d   = store_data;
                size_d = mem_size;
                uns_d  = mem_unsigned;
                wr_d   = MemWrite;
                rw_d   = RegWrite;
                m2r_d  = MemtoReg;
                dst_d  = regdst;
            end else if (in_valid) begin
                wb_rw_d  = RegWrite & ~align_err;
                wb_m2r_d = MemtoReg;
                wb_alu_d = ALUResult;
                wb_dst_d = regdst;
                err_d    = align_err;
            end
        end else if (data_ack) begin
            wb_rw_d  = rw_q;
            wb_m2r_d = m2r_q;
            wb_md_d  = wr_q ? '0 : load_ext;
            wb_alu_d = alu_q;
            wb_dst_d = dst_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alu_q    <= '0;
            sd_q     <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            wr_q     <= 1'b0;
            rw_q     <= 1'b0;
            m2r_q    <= 1'b0;
            dst_q    <= '0;
            wb_rw_q  <= 1'b0;
            wb_m2r_q <= 1'b0;
            wb_md_q  <= '0;
            wb_alu_q <= '0;
            wb_dst_q <= '0;
            err_q    <= 1'b0;
        end else begin
            alu_q    <= alu_d;
            sd_q     <= sd_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            wr_q     <= wr_d;
            rw_q     <= rw_d;
            m2r_q    <= m2r_d;
            dst_q    <= dst_d;
            wb_rw_q  <= wb_rw_d;
            wb_m2r_q <= wb_m2r_d;
            wb_md_q  <= wb_md_d;
            wb_alu_q <= wb_alu_d;
            wb_dst_q <= wb_dst_d;
            err_q    <= err_d;
        end
    end

    assign mem_RegWrite  = wb_rw_q;
    assign mem_MemtoReg  = wb_m2r_q;
    assign mem_memdata   = wb_md_q;
    assign mem_ALUResult = wb_alu_q;
    assign mem_regdst    = wb_dst_q;
    assign mem_addr_err  = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage plus hand sequences for wait states and reset abort.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, MemRead, MemWrite, RegWrite, MemtoReg;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] ALUResult, store_data;
    logic [4:0]  regdst;
    logic        mem_stall, data_req, data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_be;
    logic [31:0] data_wdata, data_rdata;
    logic        data_ack;
    logic        mem_RegWrite, mem_MemtoReg;
    logic [31:0] mem_memdata, mem_ALUResult;
    logic [4:0]  mem_regdst;
    logic        mem_addr_err;

    int total = 0;
    int bad   = 0;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .ALUResult(ALUResult),
        .store_data(store_data), .regdst(regdst), .mem_stall(mem_stall),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_be(data_be), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_ack(data_ack), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
        .mem_memdata(mem_memdata), .mem_ALUResult(mem_ALUResult),
        .mem_regdst(mem_regdst), .mem_addr_err(mem_addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, rw, m2r;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] alu, sd, rdata;
        logic [4:0]  dst;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_md;
        logic        chk_md;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic rw,
                         input logic m2r, input logic [1:0] sz, input logic uns,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dst);
        in_valid = v; MemRead = rd; MemWrite = wr; RegWrite = rw; MemtoReg = m2r;
        mem_size = sz; mem_unsigned = uns; ALUResult = alu; store_data = sd; regdst = dst;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        string n;
        v = vt[idx];
        n = $sformatf("v%0d", idx);
        drive(1'b1, v.rd, v.wr, v.rw, v.m2r, v.sz, v.uns, v.alu, v.sd, v.dst);
        data_ack = 1'b0;
        #1;
        if (v.rd || v.wr) begin
            chk({n, ".stall_idle"}, 32'(mem_stall), 32'd1);
            step();
            chk({n, ".req"}, 32'(data_req), 32'd1);
            chk({n, ".wr"}, 32'(data_wr), 32'(v.wr));
            chk({n, ".addr"}, data_addr, v.alu & 32'hFFFF_FFFC);
            chk({n, ".be"}, 32'(data_be), 32'(v.e_be));
            if (v.wr) chk({n, ".wdata"}, data_wdata, v.e_wdata);
            chk({n, ".stall_wait"}, 32'(mem_stall), 32'd1);
            chk({n, ".bubble_rw"}, 32'(mem_RegWrite), 32'd0);
            data_ack = 1'b1;
            data_rdata = v.rdata;
            in_valid = 1'b0;
            #1;
            chk({n, ".stall_ack"}, 32'(mem_stall), 32'd0);
            step();
            data_ack = 1'b0;
            chk({n, ".req_after"}, 32'(data_req), 32'd0);
        end else begin
            chk({n, ".stall"}, 32'(mem_stall), 32'd0);
            step();
            in_valid = 1'b0;
        end
        chk({n, ".rw"}, 32'(mem_RegWrite), 32'(v.rw));
        chk({n, ".m2r"}, 32'(mem_MemtoReg), 32'(v.m2r));
        chk({n, ".alu"}, mem_ALUResult, v.alu);
        chk({n, ".dst"}, 32'(mem_regdst), 32'(v.dst));
        chk({n, ".err"}, 32'(mem_addr_err), 32'd0);
        if (v.chk_md) chk({n, ".md"}, mem_memdata, v.e_md);
        step();
        chk({n, ".bubble_next"}, 32'(mem_RegWrite), 32'd0);
    endtask

    initial begin
        int req_cnt, stall_cnt, rw_cnt;
        // rd wr rw m2r sz uns alu sd rdata dst be wdata md chk_md
        vt[0]  = '{1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,32'h5,32'h0,32'h0,5'd3,4'h0,32'h0,32'h0,1'b1};
        vt[1]  = '{1'b1,1'b0,1'b1,1'b1,2'b00,1'b0,32'h203,32'h0,32'h80AABBCC,5'd8,4'b1000,32'h0,32'hFFFFFF80,1'b1};
        vt[2]  = '{1'b1,1'b0,1'b1,1'b1,2'b00,1'b1,32'h203,32'h0,32'h80AABBCC,5'd9,4'b1000,32'h0,32'h00000080,1'b1};
        vt[3]  = '{1'b1,1'b0,1'b1,1'b1,2'b01,1'b0,32'h102,32'h0,32'h80017FFF,5'd10,4'b1100,32'h0,32'hFFFF8001,1'b1};
        vt[4]  = '{1'b1,1'b0,1'b1,1'b1,2'b01,1'b1,32'h100,32'h0,32'h8001F00F,5'd11,4'b0011,32'h0,32'h0000F00F,1'b1};
        vt[5]  = '{1'b1,1'b0,1'b1,1'b1,2'b00,1'b0,32'h101,32'h0,32'h11223344,5'd12,4'b0010,32'h0,32'h00000033,1'b1};
        vt[6]  = '{1'b0,1'b1,1'b0,1'b0,2'b01,1'b0,32'h302,32'h1234ABCD,32'h0,5'd0,4'b1100,32'hABCDABCD,32'h0,1'b0};
        vt[7]  = '{1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,32'h001,32'h000000A5,32'h0,5'd0,4'b0010,32'hA5A5A5A5,32'h0,1'b0};
        vt[8]  = '{1'b0,1'b1,1'b0,1'b0,2'b10,1'b0,32'h40,32'hCAFEF00D,32'h0,5'd0,4'b1111,32'hCAFEF00D,32'h0,1'b0};
        vt[9]  = '{1'b1,1'b0,1'b1,1'b1,2'b10,1'b0,32'h104,32'h0,32'h01234567,5'd13,4'b1111,32'h0,32'h01234567,1'b1};
        vt[10] = '{1'b1,1'b0,1'b1,1'b1,2'b11,1'b0,32'h108,32'h0,32'h89ABCDEF,5'd14,4'b1111,32'h0,32'h89ABCDEF,1'b1};
        vt[11] = '{1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,32'hFFFFFFFF,32'h0,32'h0,5'd31,4'h0,32'h0,32'h0,1'b1};
        vt[12] = '{1'b1,1'b0,1'b1,1'b1,2'b00,1'b0,32'h200,32'h0,32'h0000007F,5'd15,4'b0001,32'h0,32'h0000007F,1'b1};

        resetn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
        data_ack = 1'b0;
        data_rdata = 32'h0;
        #12;
        chk("rst.req", 32'(data_req), 32'd0);
        chk("rst.stall", 32'(mem_stall), 32'd0);
        chk("rst.rw", 32'(mem_RegWrite), 32'd0);
        chk("rst.alu", mem_ALUResult, 32'd0);
        chk("rst.md", mem_memdata, 32'd0);
        chk("rst.err", 32'(mem_addr_err), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        for (int i = 0; i < 13; i++) run_vec(i);

        // LW with three ACCESS cycles, ack in the third
        req_cnt = 0; stall_cnt = 0; rw_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5);
        for (int c = 0; c < 7; c++) begin
            if (c == 3) begin
                data_ack = 1'b1;
                data_rdata = 32'hDEADBEEF;
                in_valid = 1'b0;
            end
            #1;
            if (data_req) begin
                req_cnt++;
                chk("lw3.be", 32'(data_be), 32'hF);
                chk("lw3.addr", data_addr, 32'h100);
            end
            if (mem_stall) stall_cnt++;
            if (mem_RegWrite) begin
                rw_cnt++;
                chk("lw3.md", mem_memdata, 32'hDEADBEEF);
                chk("lw3.dst", 32'(mem_regdst), 32'd5);
            end
            step();
            if (c == 3) data_ack = 1'b0;
        end
        chk("lw3.req_cycles", 32'(req_cnt), 32'd3);
        chk("lw3.stall_cycles", 32'(stall_cnt), 32'd3);
        chk("lw3.rw_pulses", 32'(rw_cnt), 32'd1);

        // ack while idle must do nothing
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
        chk("idle_ack.req", 32'(data_req), 32'd0);
        chk("idle_ack.rw", 32'(mem_RegWrite), 32'd0);

        // reset asserted in the middle of an access
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h180, 32'h0, 5'd6);
        step();
        chk("abort.req_before", 32'(data_req), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("abort.req", 32'(data_req), 32'd0);
        chk("abort.stall", 32'(mem_stall), 32'd0);
        chk("abort.rw", 32'(mem_RegWrite), 32'd0);
        chk("abort.dst", 32'(mem_regdst), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        step();
        chk("abort.no_wb", 32'(mem_RegWrite), 32'd0);
        run_vec(9);

`ifdef MEM_ALIGN_CHECK_EN
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 5'd7);
        #1;
        chk("mis.stall", 32'(mem_stall), 32'd0);
        step();
        in_valid = 1'b0;
        chk("mis.req", 32'(data_req), 32'd0);
        chk("mis.err", 32'(mem_addr_err), 32'd1);
        chk("mis.rw", 32'(mem_RegWrite), 32'd0);
        step();
        chk("mis.err_clear", 32'(mem_addr_err), 32'd0);
        chk("mis.req_after", 32'(data_req), 32'd0);
`else
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 5'd7);
        step();
        chk("mis.addr", data_addr, 32'h100);
        chk("mis.be", 32'(data_be), 32'hF);
        data_ack = 1'b1; data_rdata = 32'hCAFEBABE; in_valid = 1'b0;
        step();
        data_ack = 1'b0;
        chk("mis.md", mem_memdata, 32'hCAFEBABE);
        chk("mis.err", 32'(mem_addr_err), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h103, 32'h0, 5'd7);
        step();
        chk("mish.be", 32'(data_be), 32'hC);
        data_ack = 1'b1; data_rdata = 32'hBEEF1234; in_valid = 1'b0;
        step();
        data_ack = 1'b0;
        chk("mish.md", mem_memdata, 32'hFFFFBEEF);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
